dcmi_tx: RTL

- Frame-timed DCMI byte-stream transmitter: the read-side consumer of the 32-bit ping-pong word buffer.
- Pulls 32-bit words over the buffer's rd_rdy/rd_req handshake, unpacks each word LSB byte first, and drives a DCMI-style vsync/hsync/8-bit data stream with programmable blanking.
- Used as the on-chip sensor emulator and loopback source that feeds the DCMI receive path.

---
 rtl/dcmi_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dcmi_tx.sv
// DCMI-style byte-stream transmitter: pulls 32-bit words from the ping-pong buffer and
// drives vsync/hsync/de/data with programmable blanking. Outputs are registered.
//
// state | meaning
// IDLE  | waiting for start
// VSYNC | vsync pulse, VS_LEN cycles
// HBLK  | horizontal blanking before a line; prefetches the line's first word
// LINE  | emitting H_ACTIVE bytes, stalling whenever the word buffer is empty
// VBLK  | vertical blanking after the last line; done pulses on exit
module dcmi_tx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int VS_LEN   = 4,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        block_en,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  input  logic        rd_rdy,
  output logic        rd_req,
  input  logic [31:0] rd_data,
  output logic        dcmi_vsync,
  output logic        dcmi_hsync,
  output logic        dcmi_de,
  output logic [7:0]  dcmi_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] VSYNC = 3'd1;
  localparam logic [2:0] HBLK  = 3'd2;
  localparam logic [2:0] LINE  = 3'd3;
  localparam logic [2:0] VBLK  = 3'd4;

  localparam logic [15:0] H_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] WORDS   = 16'(H_ACTIVE / 4);
  localparam logic [15:0] VS_LOAD = 16'(VS_LEN - 1);
  localparam logic [15:0] HB_LOAD = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LOAD = 16'(V_BLANK - 1);

  logic [2:0]  state;
  logic [15:0] tmr;
  logic [15:0] byte_cnt;
  logic [15:0] line_cnt;
  logic [15:0] word_cnt;
  logic [31:0] wbuf;
  logic [2:0]  bcnt;

  logic emit;
  logic more_words;
  logic line_end;
  logic rd_vld;

  assign emit       = (state == LINE) && (bcnt != 3'd0);
  assign more_words = word_cnt < WORDS;
  assign line_end   = emit && (byte_cnt == H_LAST);

  // Refill when empty, or just-in-time as the last buffered byte leaves, so a
  // steady rd_rdy gives one byte per cycle without bubbles.
  always_comb begin
    rd_req = 1'b0;
    if (!rst && block_en && rd_rdy && more_words) begin
      if (state == HBLK && bcnt == 3'd0)
        rd_req = 1'b1;
      else if (state == LINE && (bcnt == 3'd0 || (bcnt == 3'd1 && emit)))
        rd_req = 1'b1;
    end
  end

  assign rd_vld = rd_req;

  always_ff @(posedge clk) begin
    if (rst || !block_en) begin
      state      <= IDLE;
      tmr        <= '0;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      word_cnt   <= '0;
      wbuf       <= '0;
      bcnt       <= '0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dcmi_vsync <= 1'b0;
      dcmi_hsync <= 1'b0;
      dcmi_de    <= 1'b0;
      dcmi_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= VSYNC;
            tmr      <= VS_LOAD;
            byte_cnt <= '0;
            line_cnt <= '0;
          end
        end
        VSYNC: begin
          if (tmr == 16'd0) begin
            state <= HBLK;
            tmr   <= HB_LOAD;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        HBLK: begin
          if (tmr == 16'd0) state <= LINE;
          else              tmr   <= tmr - 16'd1;
        end
        LINE: begin
          if (line_end) begin
            byte_cnt <= '0;
            if (line_cnt == V_LAST) begin
              state <= VBLK;
              tmr   <= VB_LOAD;
            end else begin
              state    <= HBLK;
              tmr      <= HB_LOAD;
              line_cnt <= line_cnt + 16'd1;
            end
          end else if (emit) begin
            byte_cnt <= byte_cnt + 16'd1;
          end
        end
        VBLK: begin
          if (tmr == 16'd0) state <= IDLE;
          else              tmr   <= tmr - 16'd1;
        end
        default: state <= IDLE;
      endcase

      // line_end never coincides with a fetch: the line has no unfetched words left
      if (line_end || (state == IDLE && start))
        word_cnt <= '0;
      else if (rd_vld)
        word_cnt <= word_cnt + 16'd1;

      if (rd_vld) begin
        wbuf <= rd_data;
        bcnt <= 3'd4;
      end else if (emit) begin
        wbuf <= {8'd0, wbuf[31:8]};
        bcnt <= bcnt - 3'd1;
      end

      if (state == LINE && bcnt == 3'd0)
        underrun <= 1'b1;

      busy       <= (state != IDLE);
      done       <= (state == VBLK) && (tmr == 16'd0);
      dcmi_vsync <= (state == VSYNC);
      dcmi_hsync <= (state == LINE);
      dcmi_de    <= emit;
      if (emit)
        dcmi_data <= wbuf[7:0];
      else if (state != LINE)
        dcmi_data <= '0;
    end
  end

endmodule
